// File: rtl/spike_fifo_slave_pkg.sv
// Shared register map, bit positions and FIFO entry layout for spike_fifo_slave.
// SPIKE_FIFO_TIMESTAMP_EN adds a 16-bit timestamp field to each entry.
package spike_fifo_pkg;

    localparam logic [4:0] OFF_DATA   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_THRESH = 5'h0C;
    localparam logic [4:0] OFF_TS     = 5'h10;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERFLOW = 3;
    localparam int ST_COUNT_LSB = 16;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int PAYLOAD_W = 32;
    localparam int TS_W      = 16;

    typedef struct packed {
`ifdef SPIKE_FIFO_TIMESTAMP_EN
        logic [TS_W-1:0]      ts;
`endif
        logic [PAYLOAD_W-1:0] payload;
    } spike_entry_t;

endpackage

// File: rtl/spike_fifo_slave_if.sv
// Simple bus with a fixed one-cycle response: m_ready acks writes, m_rvalid carries read data.
interface bus_simple_if;
    logic        m_valid;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport master (
        output m_valid, m_write, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        input  m_valid, m_write, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/spike_fifo_slave_sync_fifo.sv
// Register-array synchronous FIFO with head-of-queue output and a flush that wins over push/pop.
// Caller gates push on !full and pop on !empty; the FIFO also guards internally.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Power-of-two depth lets the pointers wrap naturally
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/spike_fifo_slave.sv
// Spike-event FIFO drained over the simple bus, with threshold/overflow interrupt.
// Optional feature macro: SPIKE_FIFO_TIMESTAMP_EN (per-entry 16-bit push timestamp, read at TS).
module spike_fifo_slave
    import spike_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          DEPTH     = 16,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_simple_if.slave       bus,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              irq
);

    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int CNT_BITS = (CW > 8) ? 8 : CW;

    logic       in_win, any_rd, any_wr, is_rd, is_wr;
    logic [4:0] off;
    logic       data_rd, status_wr, ctrl_wr, thresh_wr, flush;

    assign in_win    = (bus.m_addr[31:5] == BASE_ADDR[31:5]);
    assign off       = {bus.m_addr[4:2], 2'b00};
    assign any_rd    = bus.m_valid && !bus.m_write;
    assign any_wr    = bus.m_valid && bus.m_write;
    assign is_rd     = any_rd && in_win;
    assign is_wr     = any_wr && in_win;
    assign data_rd   = is_rd && (off == OFF_DATA);
    assign status_wr = is_wr && (off == OFF_STATUS) && bus.m_wstrb[0];
    assign ctrl_wr   = is_wr && (off == OFF_CTRL) && bus.m_wstrb[0];
    assign thresh_wr = is_wr && (off == OFF_THRESH) && bus.m_wstrb[0];
    assign flush     = ctrl_wr && bus.m_wdata[CTRL_FLUSH];

    logic unused_bits;
    assign unused_bits = ^{bus.m_addr[1:0], bus.m_wdata[31:8], bus.m_wstrb[3:1]};

    logic          enable_q, enable_d;
    logic          irq_en_q, irq_en_d;
    logic [7:0]    thresh_q, thresh_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          ready_q, ready_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;
    logic [15:0]   ts_rd;

    spike_entry_t  push_entry, head_entry;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign fifo_push = push_valid && enable_q && !fifo_full && !flush;
    assign fifo_pop  = data_rd && !fifo_empty;

`ifdef SPIKE_FIFO_TIMESTAMP_EN
    logic [15:0] ts_cnt_q, ts_cnt_d;
    logic [15:0] ts_q, ts_d;

    assign ts_cnt_d = ts_cnt_q + 16'd1;
    assign ts_d     = fifo_pop ? head_entry.ts : ts_q;
    assign ts_rd    = ts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
        end
    end
`else
    assign ts_rd = '0;
`endif

    always_comb begin
        push_entry         = '0;
        push_entry.payload = PAYLOAD_W'(push_data);
`ifdef SPIKE_FIFO_TIMESTAMP_EN
        push_entry.ts      = ts_cnt_q;
`endif
    end

    sync_fifo #(
        .WIDTH ($bits(spike_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .din_i   (push_entry),
        .dout_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sticky flags: a set in the same cycle as a W1C clear wins
    always_comb begin
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (ctrl_wr) begin
            enable_d = bus.m_wdata[CTRL_ENABLE];
            irq_en_d = bus.m_wdata[CTRL_IRQ_EN];
        end
        if (thresh_wr) thresh_d = bus.m_wdata[7:0];
        if (status_wr) begin
            if (bus.m_wdata[ST_OVERFLOW])  ovf_d = 1'b0;
            if (bus.m_wdata[ST_UNDERFLOW]) udf_d = 1'b0;
        end
        if (push_valid && enable_q && fifo_full && !flush) ovf_d = 1'b1;
        if (data_rd && fifo_empty) udf_d = 1'b1;
    end

    logic [31:0] status_word, rd_mux;

    always_comb begin
        status_word                           = '0;
        status_word[ST_EMPTY]                 = fifo_empty;
        status_word[ST_FULL]                  = fifo_full;
        status_word[ST_OVERFLOW]              = ovf_q;
        status_word[ST_UNDERFLOW]             = udf_q;
        status_word[ST_COUNT_LSB +: CNT_BITS] = fifo_count[CNT_BITS-1:0];

        rd_mux = '0;
        if (in_win) begin
            case (off)
                OFF_DATA:   rd_mux = fifo_empty ? 32'd0 : head_entry.payload;
                OFF_STATUS: rd_mux = status_word;
                OFF_CTRL:   rd_mux = {30'd0, irq_en_q, enable_q};
                OFF_THRESH: rd_mux = {24'd0, thresh_q};
                OFF_TS:     rd_mux = {16'd0, ts_rd};
                default:    rd_mux = '0;
            endcase
        end
    end

    assign ready_d  = any_wr;
    assign rvalid_d = any_rd;
    assign rdata_d  = any_rd ? rd_mux : 32'd0;
    assign irq_d    = irq_en_q && (((thresh_q != 8'd0) && (16'(fifo_count) >= 16'(thresh_q))) || ovf_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.m_ready  = ready_q;
    assign bus.m_rvalid = rvalid_q;
    assign bus.m_rdata  = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_spike_fifo_slave.sv
// Directed self-checking bench for spike_fifo_slave (default build, timestamps disabled).
module tb_spike_fifo_slave;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_data = '0;
    logic        irq;
    int          n_chk = 0;
    int          n_pass = 0;

    bus_simple_if bus_if ();

    spike_fifo_slave #(.BASE_ADDR(BASE), .DEPTH(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .push_valid (push_valid),
        .push_data  (push_data),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // All tasks start and end on a falling edge
    task automatic bus_idle();
        bus_if.m_valid = 1'b0;
        bus_if.m_write = 1'b0;
        bus_if.m_addr  = '0;
        bus_if.m_wdata = '0;
        bus_if.m_wstrb = '0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
        bus_if.m_valid = 1'b1;
        bus_if.m_write = 1'b1;
        bus_if.m_addr  = addr;
        bus_if.m_wdata = data;
        bus_if.m_wstrb = strb;
        @(negedge clk);
        bus_idle();
        check({tag, ".ready"}, {31'd0, bus_if.m_ready}, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_if.m_valid = 1'b1;
        bus_if.m_write = 1'b0;
        bus_if.m_addr  = addr;
        @(negedge clk);
        bus_idle();
        check({tag, ".rvalid"}, {31'd0, bus_if.m_rvalid}, 32'd1);
        check(tag, bus_if.m_rdata, exp);
    endtask

    task automatic push(input logic [31:0] d);
        push_valid = 1'b1;
        push_data  = d;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    initial begin
        bus_idle();
        repeat (3) @(negedge clk);
        check("rst.ready", {31'd0, bus_if.m_ready}, 32'd0);
        check("rst.rvalid", {31'd0, bus_if.m_rvalid}, 32'd0);
        check("rst.rdata", bus_if.m_rdata, 32'd0);
        check("rst.irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        rd("idle.status", BASE + 32'h04, 32'h0000_0001);
        check("idle.irq", {31'd0, irq}, 32'd0);

        // Fill, overflow, drain
        wr("fill.ctrl", BASE + 32'h08, 32'h1, 4'h1);
        for (int i = 0; i < 16; i++) push(32'hA0 + i);
        rd("fill.status", BASE + 32'h04, 32'h0010_0002);
        push(32'hFF);
        rd("ovf.status", BASE + 32'h04, 32'h0010_0006);
        wr("ovf.clr", BASE + 32'h04, 32'h4, 4'h1);
        rd("ovf.cleared", BASE + 32'h04, 32'h0010_0002);
        for (int i = 0; i < 16; i++) rd($sformatf("drain%0d", i), BASE, 32'hA0 + i);
        rd("udf.data", BASE, 32'h0);
        rd("udf.status", BASE + 32'h04, 32'h0000_0009);
        wr("udf.clr", BASE + 32'h04, 32'h8, 4'h1);
        rd("udf.cleared", BASE + 32'h04, 32'h0000_0001);

        // Concurrent push and pop with three queued
        push(32'h11); push(32'h22); push(32'h33);
        push_valid = 1'b1;
        push_data  = 32'h44;
        rd("conc.data", BASE, 32'h11);
        push_valid = 1'b0;
        rd("conc.status", BASE + 32'h04, 32'h0003_0000);
        wr("flush", BASE + 32'h08, 32'h5, 4'h1);
        rd("flush.status", BASE + 32'h04, 32'h0000_0001);
        rd("flush.ctrl", BASE + 32'h08, 32'h1);

        // Threshold interrupt
        wr("irq.thresh", BASE + 32'h0C, 32'h4, 4'h1);
        wr("irq.ctrl", BASE + 32'h08, 32'h3, 4'h1);
        for (int i = 0; i < 4; i++) push(32'h51 + i);
        check("irq.lag1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq.set", {31'd0, irq}, 32'd1);
        rd("irq.pop", BASE, 32'h51);
        check("irq.hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq.clr", {31'd0, irq}, 32'd0);
        wr("dis.ctrl", BASE + 32'h08, 32'h2, 4'h1);
        push(32'h99);
        rd("dis.status", BASE + 32'h04, 32'h0003_0000);

        // Back-to-back bus traffic
        bus_if.m_valid = 1'b1; bus_if.m_write = 1'b1;
        bus_if.m_addr = BASE + 32'h08; bus_if.m_wdata = 32'h3; bus_if.m_wstrb = 4'h1;
        @(negedge clk);
        check("b2b.wr.ready", {31'd0, bus_if.m_ready}, 32'd1);
        check("b2b.wr.rvalid", {31'd0, bus_if.m_rvalid}, 32'd0);
        bus_if.m_write = 1'b0; bus_if.m_addr = BASE + 32'h08;
        @(negedge clk);
        check("b2b.rd1.rvalid", {31'd0, bus_if.m_rvalid}, 32'd1);
        check("b2b.rd1.ready", {31'd0, bus_if.m_ready}, 32'd0);
        check("b2b.rd1.data", bus_if.m_rdata, 32'h3);
        bus_if.m_addr = BASE + 32'h1C;
        @(negedge clk);
        check("b2b.rd2.rvalid", {31'd0, bus_if.m_rvalid}, 32'd1);
        check("b2b.rd2.data", bus_if.m_rdata, 32'h0);
        bus_idle();
        @(negedge clk);
        check("b2b.idle.rvalid", {31'd0, bus_if.m_rvalid}, 32'd0);
        check("b2b.idle.rdata", bus_if.m_rdata, 32'h0);

        wr("nostrb", BASE + 32'h08, 32'h0, 4'h0);
        rd("nostrb.ctrl", BASE + 32'h08, 32'h3);
        wr("oow.wr", 32'h5000_0008, 32'h0, 4'hF);
        rd("oow.ctrl_lowbits", BASE + 32'h0B, 32'h3);
        rd("oow.rd", 32'h5000_0000, 32'h0);
`ifndef SPIKE_FIFO_TIMESTAMP_EN
        rd("ts.off", BASE + 32'h10, 32'h0);
`endif

        // Reset during a read cancels the response
        rst_n = 1'b0;
        bus_if.m_valid = 1'b1; bus_if.m_write = 1'b0; bus_if.m_addr = BASE + 32'h04;
        @(negedge clk);
        bus_idle();
        check("rstmid.rvalid", {31'd0, bus_if.m_rvalid}, 32'd0);
        check("rstmid.rdata", bus_if.m_rdata, 32'h0);
        check("rstmid.irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        rd("rstmid.status", BASE + 32'h04, 32'h0000_0001);
        rd("rstmid.ctrl", BASE + 32'h08, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got %0d checks expected completion", n_chk);
        $fatal(1, "timeout");
    end
endmodule
